// File: rtl/rcu_fair_sched.sv
// Fair process scheduler for the RCU model: registers a per-cycle process select
// from a free choice, overriding it whenever a process has waited MAXWAIT-1 enabled cycles.
module rcu_fair_sched #(
  parameter int unsigned NRDR    = 4,
  parameter int unsigned SELMSB  = 2,
  parameter int unsigned MAXWAIT = 8,
  parameter int unsigned AGEW    = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [SELMSB:0]   nd_choice,
  input  logic              hold,
  output logic [SELMSB:0]   select,
  output logic              select_valid,
  output logic              forced,
  output logic              round_done
);

  localparam int unsigned     NP      = NRDR + 1;
  localparam int unsigned     SELW    = SELMSB + 1;
  localparam logic [AGEW-1:0] AGE_MAX = AGEW'(MAXWAIT - 1);
  localparam logic [SELW-1:0] UPD_SEL = SELW'(NRDR);

  logic [AGEW-1:0] age_q [NP];
  logic [AGEW-1:0] age_d [NP];
  logic [NP-1:0]   seen_q, seen_d, seen_nx;
  logic [SELW-1:0] select_q, grant_d, cand;
  logic            valid_q, forced_q, forced_d, rd_q, rd_d;

  // Grant decision, age update and round tracking for one enabled cycle
  always_comb begin
    cand     = (nd_choice > UPD_SEL) ? UPD_SEL : nd_choice;
    grant_d  = cand;
    forced_d = 1'b0;
    // Downward scan leaves the lowest overdue index as the winner
    for (int p = int'(NP) - 1; p >= 0; p--) begin
      if (age_q[p] == AGE_MAX) begin
        grant_d  = SELW'(p);
        forced_d = 1'b1;
      end
    end
    for (int p = 0; p < int'(NP); p++) begin
      if (grant_d == SELW'(p)) begin
        age_d[p] = '0;
      end else if (age_q[p] == AGE_MAX) begin
        age_d[p] = age_q[p];
      end else begin
        age_d[p] = age_q[p] + AGEW'(1);
      end
    end
    seen_nx = seen_q | (NP'(1) << grant_d);
    rd_d    = &seen_nx;
    seen_d  = rd_d ? '0 : seen_nx;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      select_q <= '0;
      valid_q  <= 1'b0;
      forced_q <= 1'b0;
      rd_q     <= 1'b0;
      seen_q   <= '0;
      for (int p = 0; p < int'(NP); p++) age_q[p] <= '0;
    end else if (hold) begin
      valid_q  <= 1'b0;
      forced_q <= 1'b0;
      rd_q     <= 1'b0;
    end else begin
      select_q <= grant_d;
      valid_q  <= 1'b1;
      forced_q <= forced_d;
      rd_q     <= rd_d;
      seen_q   <= seen_d;
      for (int p = 0; p < int'(NP); p++) age_q[p] <= age_d[p];
    end
  end

  assign select       = select_q;
  assign select_valid = valid_q;
  assign forced       = forced_q;
  assign round_done   = rd_q;

endmodule
